hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised register scoreboard for the pipelined CPU's issue stage, replacing the fixed load-to-use compare logic with per-register pending tracking. Each register with an in-flight write holds either a latency countdown or a wait-for-memory flag. The block asserts `stall` when an issuing instruction reads or writes a pending register. It supports fixed-latency producers (ALU, load with known latency) and variable-latency producers (data memory with a completion pulse).

## Interface
- `NREG`, 16, number of architectural registers
- `RW`, 4, register index width (log2 NREG)
- `CW`, 3, latency counter width; max fixed latency 2^CW-1
- `R0_ZERO`, 1, when 1 register 0 is never pending and writes to it are not tracked

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `iss_valid`  in  1  instruction presented at issue this cycle
- `iss_rs`  in  RW  first source register
- `iss_rs_use`  in  1  first source actually read
- `iss_rt`  in  RW  second source register
- `iss_rt_use`  in  1  second source actually read
- `iss_rd`  in  RW  destination register
- `iss_rd_wr`  in  1  instruction writes `iss_rd`
- `iss_lat`  in  CW  cycles until result is forwardable; 0 = variable latency, wait for `mem_done`
- `flush`  in  1  kill the instruction at issue this cycle
- `mem_done`  in  1  variable-latency result for `mem_done_rd` now forwardable
- `mem_done_rd`  in  RW  register completed by `mem_done`
- `stall`  out  1  hold issue stage, combinational
- `pend`  out  NREG  registered per-register pending vector
- `busy`  out  1  OR of `pend`
- `err`  out  1  sticky: `mem_done` for a register not waiting on memory

## Operation
- Per-register state: `cnt[r]` (CW bits) and `wmem[r]` (1 bit). `pending(r) = (cnt[r]!=0) | wmem[r]`. Forced 0 for r=0 when R0_ZERO=1.
- `pend[r] = pending(r)` from registered state only.
- `stall = iss_valid & ((iss_rs_use & pending(iss_rs)) | (iss_rt_use & pending(iss_rt)) | (iss_rd_wr & pending(iss_rd)))`. This covers RAW on both sources and WAW on the destination.
- `stall` is independent of `flush` and `mem_done` in the same cycle.
- Accept is `iss_valid & !stall & !flush`.
- On accept with `iss_rd_wr` and rd tracked:
  - `iss_lat!=0`: `cnt[rd] <= iss_lat`.
  - `iss_lat==0`: `wmem[rd] <= 1`.
- Every cycle, each nonzero `cnt[r]` not being loaded decrements by 1. The counter saturates at 0 and never wraps.
- `mem_done`:
  - If `wmem[mem_done_rd]` is set, clear it at the next edge.
  - Otherwise no state change and `err <= 1`.
  - A `mem_done` for r=0 with R0_ZERO=1 is ignored and does not set `err`.
- Accept to a pending rd is impossible (WAW stall), so a load and a clear never target the same entry in one cycle.
- `mem_done` for register X and issue reading X in the same cycle: `stall` is still 1 that cycle. The stall releases the next cycle.
- `flush` only suppresses the current issue. Entries already recorded (older instructions) keep counting or waiting.
- Stall with no accept: no state changes other than decrement and `mem_done` handling.

## Timing
- Reset (async assert, any cycle, mid-countdown included): all `cnt`=0, `wmem`=0, `pend`=0, `busy`=0, `err`=0, so `stall`=0.
- Release is synchronous to the first rising edge after `rst` falls.
- Accept at cycle t with `iss_lat`=L: `pend[rd]`=1 during cycles t+1 … t+L, and 0 from t+L+1.
- A dependent issue at t+1 stalls L cycles and is accepted at t+L+1.
- Accept at t with `iss_lat`=0: `pend[rd]`=1 from t+1 until the cycle after `mem_done`. `mem_done` at cycle m frees a dependent issue at m+1.
- `stall` has zero-cycle latency from issue inputs. `pend`, `busy`, `err` are one cycle after the causing edge.
- `err` clears only on `rst`.

## Test plan
- Reset: assert `rst` with r5 at `cnt`=3, then release. Required: `pend`=0, `busy`=0, `err`=0, `stall`=0; an issue reading r5 is accepted immediately.
- RAW fixed latency: accept write r3 with L=2 at t; issue reading r3 from t+1. Required: `stall`=1 at t+1 and t+2, 0 at t+3; `pend`=16'h0008 during t+1..t+2.
- Variable latency: accept load r7 (L=0); hold a reader of r7 for 10 cycles; pulse `mem_done`, rd=7. Required: `stall`=1 through the `mem_done` cycle, 0 the next cycle; `err`=0.
- WAW plus flush: r2 pending; issue write r2 with reads unused. Required: `stall`=1. Then issue write r4 with `flush`=1. Required: `pend[4]` stays 0.
- R0 and spurious done: accept write r0 (L=3). Required: `pend`=0. Pulse `mem_done`, rd=9 with r9 idle. Required: `err`=1 next cycle and it stays 1; `pend` unchanged.
- Max latency with overlap: accept r1 with L=7; at t+1 accept r2 with L=1 (independent). Required: `pend[2]` clears at t+3, `pend[1]` at t+8; `busy` drops at t+8.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending tracker for the issue stage.
// Each register holds a latency countdown (fixed-latency producers) or a
// wait-for-memory flag (variable-latency producers). An issuing instruction
// that reads or writes a pending register is stalled.
module hazard_scoreboard #(
  parameter int NREG    = 16,
  parameter int RW      = 4,
  parameter int CW      = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            iss_valid_i,
  input  logic [RW-1:0]   iss_rs_i,
  input  logic            iss_rs_use_i,
  input  logic [RW-1:0]   iss_rt_i,
  input  logic            iss_rt_use_i,
  input  logic [RW-1:0]   iss_rd_i,
  input  logic            iss_rd_wr_i,
  input  logic [CW-1:0]   iss_lat_i,
  input  logic            flush_i,
  input  logic            mem_done_i,
  input  logic [RW-1:0]   mem_done_rd_i,
  output logic            stall_o,
  output logic [NREG-1:0] pend_o,
  output logic            busy_o,
  output logic            err_o
);

  // Register 0 is hard-wired when R0_ZERO is set, so it is never tracked.
  function automatic logic is_tracked(input logic [RW-1:0] r);
    return !(R0_ZERO && (r == {RW{1'b0}}));
  endfunction

  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [NREG-1:0] wmem_q, wmem_d;
  logic            err_q, err_d;
  logic [NREG-1:0] pend_s;
  logic            stall_s;
  logic            accept_s;
  logic            load_en_s;
  logic            done_trk_s;

  // Pending vector derived purely from registered state.
  always_comb begin
    pend_s = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      if (R0_ZERO && (r == 0)) begin
        pend_s[r] = 1'b0;
      end else begin
        pend_s[r] = (cnt_q[r] != {CW{1'b0}}) | wmem_q[r];
      end
    end
  end

  // RAW on either source or WAW on the destination holds issue; flush and
  // mem_done in the same cycle deliberately do not affect the stall.
  assign stall_s = iss_valid_i &
                   ((iss_rs_use_i & pend_s[iss_rs_i]) |
                    (iss_rt_use_i & pend_s[iss_rt_i]) |
                    (iss_rd_wr_i  & pend_s[iss_rd_i]));

  assign accept_s   = iss_valid_i & ~stall_s & ~flush_i;
  assign load_en_s  = accept_s & iss_rd_wr_i & is_tracked(iss_rd_i);
  assign done_trk_s = mem_done_i & is_tracked(mem_done_rd_i);

  // Next state: load on accept, otherwise count down; memory completion
  // clears the wait flag or flags a spurious completion.
  always_comb begin
    err_d = err_q | (done_trk_s & ~wmem_q[mem_done_rd_i]);
    for (int r = 0; r < NREG; r++) begin
      if (load_en_s && (iss_rd_i == RW'(r)) && (iss_lat_i != {CW{1'b0}})) begin
        cnt_d[r] = iss_lat_i;
      end else if (cnt_q[r] != {CW{1'b0}}) begin
        cnt_d[r] = cnt_q[r] - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[r] = cnt_q[r];
      end

      if (load_en_s && (iss_rd_i == RW'(r)) && (iss_lat_i == {CW{1'b0}})) begin
        wmem_d[r] = 1'b1;
      end else if (done_trk_s && (mem_done_rd_i == RW'(r))) begin
        wmem_d[r] = 1'b0;
      end else begin
        wmem_d[r] = wmem_q[r];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '{default: {CW{1'b0}}};
      wmem_q <= {NREG{1'b0}};
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wmem_q <= wmem_d;
      err_q  <= err_d;
    end
  end

  assign stall_o = stall_s;
  assign pend_o  = pend_s;
  assign busy_o  = |pend_s;
  assign err_o   = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vectors, a ready-time model of the
// scoreboard checked every cycle, plus hand-computed literal checks.
module tb_hazard_scoreboard;

  localparam int INF = 32'h7fffffff;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [3:0]  iss_rs;
  logic        iss_rs_use;
  logic [3:0]  iss_rt;
  logic        iss_rt_use;
  logic [3:0]  iss_rd;
  logic        iss_rd_wr;
  logic [2:0]  iss_lat;
  logic        flush;
  logic        mem_done;
  logic [3:0]  mem_done_rd;
  logic        stall;
  logic [15:0] pend;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard #(.NREG(16), .RW(4), .CW(3), .R0_ZERO(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .iss_valid_i(iss_valid),
    .iss_rs_i(iss_rs), .iss_rs_use_i(iss_rs_use),
    .iss_rt_i(iss_rt), .iss_rt_use_i(iss_rt_use),
    .iss_rd_i(iss_rd), .iss_rd_wr_i(iss_rd_wr),
    .iss_lat_i(iss_lat), .flush_i(flush),
    .mem_done_i(mem_done), .mem_done_rd_i(mem_done_rd),
    .stall_o(stall), .pend_o(pend), .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each register has the cycle number from which it is free
  // (INF while waiting on memory). A register is pending while cycle < ready.
  int ready_m [16] = '{default: 0};
  bit err_m = 1'b0;
  int cyc_m = 0;

  function automatic bit pend_m(input int r);
    if (r == 0) return 1'b0;
    return cyc_m < ready_m[r];
  endfunction

  function automatic logic [15:0] pendvec_m();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = pend_m(i);
    return v;
  endfunction

  function automatic bit stall_m();
    return iss_valid && ((iss_rs_use && pend_m(int'(iss_rs))) ||
                         (iss_rt_use && pend_m(int'(iss_rt))) ||
                         (iss_rd_wr  && pend_m(int'(iss_rd))));
  endfunction

  // Advance the model at each clock edge from the inputs of the ending cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ready_m[i] <= 0;
      err_m <= 1'b0;
    end else begin
      if (mem_done && mem_done_rd != 4'd0) begin
        if (ready_m[mem_done_rd] == INF) ready_m[mem_done_rd] <= cyc_m + 1;
        else err_m <= 1'b1;
      end
      if (iss_valid && !stall_m() && !flush && iss_rd_wr && iss_rd != 4'd0)
        ready_m[iss_rd] <= (iss_lat != 3'd0) ? cyc_m + int'(iss_lat) + 1 : INF;
    end
    cyc_m <= cyc_m + 1;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, on the falling edge.
  always @(negedge clk) begin
    check("stall_model", {15'd0, stall}, {15'd0, stall_m()});
    check("pend_model",  pend,           pendvec_m());
    check("busy_model",  {15'd0, busy},  {15'd0, (pendvec_m() != 16'd0)});
    check("err_model",   {15'd0, err},   {15'd0, err_m});
  end

  task automatic drive(input logic v, input logic [3:0] rs, input logic rsu,
                       input logic [3:0] rt, input logic rtu,
                       input logic [3:0] rd, input logic wr, input logic [2:0] lat,
                       input logic fl, input logic md, input logic [3:0] mdrd);
    @(posedge clk);
    #1;
    iss_valid = v; iss_rs = rs; iss_rs_use = rsu; iss_rt = rt; iss_rt_use = rtu;
    iss_rd = rd; iss_rd_wr = wr; iss_lat = lat; flush = fl;
    mem_done = md; mem_done_rd = mdrd;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] rd, input logic [2:0] lat);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, rd, 1'b1, lat, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic rd_src(input logic [3:0] rs, input logic md, input logic [3:0] mdrd);
    drive(1'b1, rs, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, md, mdrd);
  endtask

  initial begin
    iss_valid = 1'b0; iss_rs = 4'd0; iss_rs_use = 1'b0; iss_rt = 4'd0; iss_rt_use = 1'b0;
    iss_rd = 4'd0; iss_rd_wr = 1'b0; iss_lat = 3'd0; flush = 1'b0;
    mem_done = 1'b0; mem_done_rd = 4'd0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-countdown: r5 loaded with 4, reset while it holds 3.
    wr(4'd5, 3'd4);
    idle();
    check("r5_pending", pend, 16'h0020);
    idle();
    #1 rst = 1'b1;
    #1;
    check("rst_pend", pend, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_err",  {15'd0, err},  16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_src(4'd5, 1'b0, 4'd0);
    check("rst_read_r5_stall", {15'd0, stall}, 16'd0);

    // RAW with fixed latency 2 on r3.
    wr(4'd3, 3'd2);
    check("raw_accept_stall", {15'd0, stall}, 16'd0);
    rd_src(4'd3, 1'b0, 4'd0);
    check("raw_t1_stall", {15'd0, stall}, 16'd1);
    check("raw_t1_pend",  pend, 16'h0008);
    rd_src(4'd3, 1'b0, 4'd0);
    check("raw_t2_stall", {15'd0, stall}, 16'd1);
    check("raw_t2_pend",  pend, 16'h0008);
    rd_src(4'd3, 1'b0, 4'd0);
    check("raw_t3_stall", {15'd0, stall}, 16'd0);
    check("raw_t3_pend",  pend, 16'h0000);

    // Variable latency load to r7, released by mem_done.
    wr(4'd7, 3'd0);
    for (int i = 0; i < 10; i++) begin
      rd_src(4'd7, 1'b0, 4'd0);
      check("var_wait_stall", {15'd0, stall}, 16'd1);
    end
    rd_src(4'd7, 1'b1, 4'd7);
    check("var_done_cycle_stall", {15'd0, stall}, 16'd1);
    rd_src(4'd7, 1'b0, 4'd0);
    check("var_after_done_stall", {15'd0, stall}, 16'd0);
    check("var_err", {15'd0, err}, 16'd0);

    // WAW on r2 (sources unused but aliased to r2), then flushed write to r4.
    wr(4'd2, 3'd5);
    drive(1'b1, 4'd2, 1'b0, 4'd2, 1'b0, 4'd2, 1'b1, 3'd1, 1'b0, 1'b0, 4'd0);
    check("waw_stall", {15'd0, stall}, 16'd1);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 3'd2, 1'b1, 1'b0, 4'd0);
    check("flush_stall", {15'd0, stall}, 16'd0);
    idle();
    check("flush_pend4", {15'd0, pend[4]}, 16'd0);
    check("flush_pend2", {15'd0, pend[2]}, 16'd1);
    repeat (6) idle();

    // r0 is never tracked; mem_done on r0 ignored; spurious done on r9.
    wr(4'd0, 3'd3);
    idle();
    check("r0_pend", pend, 16'h0000);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd0);
    idle();
    check("r0_done_err", {15'd0, err}, 16'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd9);
    idle();
    check("spurious_err", {15'd0, err}, 16'd1);
    check("spurious_pend", pend, 16'h0000);
    repeat (3) idle();
    check("err_sticky", {15'd0, err}, 16'd1);

    // Max latency 7 on r1 overlapping latency 1 on r2.
    wr(4'd1, 3'd7);
    wr(4'd2, 3'd1);
    check("ovl_t1_pend", pend, 16'h0002);
    idle();
    check("ovl_t2_pend", pend, 16'h0006);
    for (int k = 3; k <= 7; k++) begin
      idle();
      check("ovl_r1_only", pend, 16'h0002);
      check("ovl_busy_hi", {15'd0, busy}, 16'd1);
    end
    idle();
    check("ovl_t8_pend", pend, 16'h0000);
    check("ovl_t8_busy", {15'd0, busy}, 16'd0);

    repeat (2) idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
